// File: rtl/input_port_flit_buffer.sv
// Per-input-port flit FIFO: captures inbound flits with their look-ahead
// route, presents the oldest entry to the decoder, returns one credit
// upstream per drained flit and flags writes into a full buffer.
//
// Handshake: the head is transferred on a rising edge where flit_v_o=1 and
// flit_rdy_i=1. flit_v_o never depends combinationally on flit_rdy_i, and
// the head stays stable while flit_v_o=1 and flit_rdy_i=0. The inbound side
// has no backpressure; upstream is throttled by credits only.
module input_port_flit_buffer #(
  parameter int FlitW    = 64,
  parameter int LaRouteW = 3,
  parameter int Depth    = 4,
  localparam int PtrW    = $clog2(Depth),
  localparam int CntW    = PtrW + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flit_v_i,
  input  logic [FlitW-1:0]    flit_i,
  input  logic [LaRouteW-1:0] flit_look_ahead_routing_i,
  output logic                flit_v_o,
  output logic [FlitW-1:0]    flit_o,
  output logic [LaRouteW-1:0] flit_look_ahead_routing_o,
  input  logic                flit_rdy_i,
  output logic                credit_o,
  output logic [CntW-1:0]     count_o,
  output logic                overflow_o
);

  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  // Storage array (intentionally not reset; contents behind count are stale)
  logic [FlitW-1:0]    mem_flit [Depth];
  logic [LaRouteW-1:0] mem_la   [Depth];

  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            credit_q;
  logic            overflow_q;

  logic full;
  logic not_empty;
  logic push;
  logic pop;
  logic drop;

  // Decide this cycle's push/pop/drop from the pre-edge occupancy
  always_comb begin
    full      = (count_q == FullCnt);
    not_empty = (count_q != '0);
    push      = flit_v_i && !full;
    drop      = flit_v_i && full;
    pop       = not_empty && flit_rdy_i;
  end

  // Write the accepted flit into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      mem_flit[wr_ptr_q] <= flit_i;
      mem_la[wr_ptr_q]   <= flit_look_ahead_routing_i;
    end
  end

  // Pointers wrap naturally at Depth because Depth is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Occupancy: unchanged when a push and a pop coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Credit pulse one cycle after each pop; overflow is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      credit_q   <= pop;
      overflow_q <= overflow_q | drop;
    end
  end

  // Head outputs come straight from registered state
  always_comb begin
    flit_v_o                  = not_empty;
    flit_o                    = mem_flit[rd_ptr_q];
    flit_look_ahead_routing_o = mem_la[rd_ptr_q];
    count_o                   = count_q;
    credit_o                  = credit_q;
    overflow_o                = overflow_q;
  end

endmodule

// File: tb/tb_input_port_flit_buffer.sv
// Bench for input_port_flit_buffer: directed scenarios followed by random
// traffic, checked every cycle against a queue-based reference model.
module tb_input_port_flit_buffer;

  localparam int FlitW    = 64;
  localparam int LaRouteW = 3;
  localparam int Depth    = 4;
  localparam int CntW     = $clog2(Depth) + 1;
  localparam int W        = FlitW + LaRouteW;

  logic                clk;
  logic                rst_n;
  logic                flit_v_i;
  logic [FlitW-1:0]    flit_i;
  logic [LaRouteW-1:0] flit_look_ahead_routing_i;
  logic                flit_v_o;
  logic [FlitW-1:0]    flit_o;
  logic [LaRouteW-1:0] flit_look_ahead_routing_o;
  logic                flit_rdy_i;
  logic                credit_o;
  logic [CntW-1:0]     count_o;
  logic                overflow_o;

  input_port_flit_buffer #(
    .FlitW(FlitW), .LaRouteW(LaRouteW), .Depth(Depth)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .flit_v_i                  (flit_v_i),
    .flit_i                    (flit_i),
    .flit_look_ahead_routing_i (flit_look_ahead_routing_i),
    .flit_v_o                  (flit_v_o),
    .flit_o                    (flit_o),
    .flit_look_ahead_routing_o (flit_look_ahead_routing_o),
    .flit_rdy_i                (flit_rdy_i),
    .credit_o                  (credit_o),
    .count_o                   (count_o),
    .overflow_o                (overflow_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] exp_q[$];      // {la, flit}, oldest first
  logic         exp_credit;
  logic         exp_ovf;
  int           credit_seen;
  int           n_checks;
  int           n_errors;

  task automatic check(input string tag, input logic [FlitW-1:0] obs,
                       input logic [FlitW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_credit = 1'b0;
    exp_ovf    = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [W-1:0] head;
    check({tag, ".v"},      FlitW'(flit_v_o),   FlitW'(exp_q.size() != 0));
    check({tag, ".count"},  FlitW'(count_o),    FlitW'(exp_q.size()));
    check({tag, ".credit"}, FlitW'(credit_o),   FlitW'(exp_credit));
    check({tag, ".ovf"},    FlitW'(overflow_o), FlitW'(exp_ovf));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check({tag, ".flit"}, flit_o, head[FlitW-1:0]);
      check({tag, ".la"}, FlitW'(flit_look_ahead_routing_o), FlitW'(head[W-1:FlitW]));
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1: drive inputs, predict from pre-edge model state,
  // advance one edge, update the model, check at posedge+1.
  task automatic step(input logic v, input logic [FlitW-1:0] d,
                      input logic [LaRouteW-1:0] la, input logic rdy,
                      input string tag);
    logic do_push, do_pop, do_drop;
    logic [W-1:0] head;
    flit_v_i                  = v;
    flit_i                    = d;
    flit_look_ahead_routing_i = la;
    flit_rdy_i                = rdy;
    #1;
    do_push = v && (exp_q.size() < Depth);
    do_drop = v && (exp_q.size() == Depth);
    do_pop  = rdy && (exp_q.size() != 0);
    if (do_pop) begin
      head = exp_q[0];
      check({tag, ".pop_data"}, flit_o, head[FlitW-1:0]);
    end
    @(posedge clk);
    #1;
    if (do_pop)  void'(exp_q.pop_front());
    if (do_push) exp_q.push_back({la, d});
    exp_credit = do_pop;
    exp_ovf    = exp_ovf | do_drop;
    if (credit_o) credit_seen++;
    check_outputs(tag);
  endtask

  task automatic idle(input logic rdy, input string tag);
    step(1'b0, '0, '0, rdy, tag);
  endtask

  task automatic do_reset();
    flit_v_i   = 1'b0;
    flit_rdy_i = 1'b0;
    rst_n      = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("post_reset");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks    = 0;
    n_errors    = 0;
    credit_seen = 0;
    rst_n       = 1'b0;
    flit_v_i    = 1'b0;
    flit_i      = '0;
    flit_look_ahead_routing_i = '0;
    flit_rdy_i  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single push, head holds while not ready
    step(1'b1, 64'h1111, 3'd2, 1'b0, "push_a");
    check("push_a.flit_direct", flit_o, 64'h1111);
    repeat (3) idle(1'b0, "hold_a");
    idle(1'b1, "drain_a");
    idle(1'b0, "drain_a_credit");

    // Fill then drain in order
    for (int i = 1; i <= 4; i++) step(1'b1, 64'(i), 3'(i), 1'b0, "fill4");
    check("fill4.count_direct", FlitW'(count_o), 64'd4);
    credit_seen = 0;
    for (int i = 0; i < 4; i++) idle(1'b1, "drain4");
    idle(1'b0, "drain4_tail");
    check("drain4.credits", FlitW'(credit_seen), 64'd4);

    // Overflow with a same-cycle pop
    for (int i = 1; i <= 4; i++) step(1'b1, 64'(i), 3'd1, 1'b0, "fill_ovf");
    step(1'b1, 64'h5, 3'd5, 1'b1, "ovf_push");
    check("ovf.count_direct", FlitW'(count_o), 64'd3);
    check("ovf.head_direct", flit_o, 64'h2);
    check("ovf.flag_direct", FlitW'(overflow_o), 64'd1);
    repeat (2) idle(1'b0, "ovf_sticky");

    // Asynchronous reset mid-operation with 3 entries and overflow set
    #2;
    rst_n = 1'b0;
    flit_v_i = 1'b0;
    flit_rdy_i = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 64'hAB, 3'd3, 1'b0, "after_rst");
    idle(1'b1, "after_rst_pop");
    idle(1'b0, "after_rst_idle");

    // Streaming: one push and one pop per cycle
    credit_seen = 0;
    step(1'b1, 64'd0, 3'd0, 1'b0, "stream0");
    for (int i = 1; i < 20; i++) step(1'b1, 64'(i), 3'(i), 1'b1, "stream");
    idle(1'b1, "stream_last");
    idle(1'b0, "stream_tail");
    check("stream.credits", FlitW'(credit_seen), 64'd20);

    // Ready while empty: nothing happens
    credit_seen = 0;
    repeat (5) idle(1'b1, "empty_rdy");
    check("empty_rdy.credits", FlitW'(credit_seen), 64'd0);

    // Random traffic, with a mid-run reset to clear the sticky flag
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step($urandom_range(0, 9) < 6, {$urandom, $urandom},
           3'($urandom_range(0, 7)), $urandom_range(0, 9) < 5, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
